// File: rtl/table_arb_pkg.sv
// Shared types and helpers for the table access arbiter: pipeline entry
// format and the round-robin pick function.
package table_arb_pkg;

   localparam int MAX_REQ  = 8;
   localparam int PTR_BITS = 3;

   typedef struct packed {
      logic                vld;
      logic [PTR_BITS-1:0] id;
   } tbl_pipe_t;

   // One-hot pick of the first set bit in req at or above ptr, wrapping at n.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                  input logic [PTR_BITS-1:0] ptr,
                                                  input int n);
      logic [MAX_REQ-1:0] g;
      logic [3:0]         idx;
      g = '0;
      for (int k = 0; k < MAX_REQ; k++) begin
         idx = {1'b0, ptr} + 4'(k);
         if (idx >= 4'(n)) idx = idx - 4'(n);
         if (k < n && g == '0 && req[idx[2:0]]) g[idx[2:0]] = 1'b1;
      end
      return g;
   endfunction

endpackage

// File: rtl/table_arb_rr.sv
// Round-robin picker: eligible vector and pointer in, one-hot grant,
// encoded grant index and any-grant flag out.
module table_arb_rr
   import table_arb_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]    eligible_i,
   input  logic [PTR_BITS-1:0] ptr_i,
   output logic [N_REQ-1:0]    grant_o,
   output logic [PTR_BITS-1:0] grant_idx_o,
   output logic                any_o
);

   logic [MAX_REQ-1:0] pick;

   always_comb begin
      pick        = rr_pick(MAX_REQ'(eligible_i), ptr_i, N_REQ);
      grant_o     = pick[N_REQ-1:0];
      any_o       = |pick;
      grant_idx_o = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick[i]) grant_idx_o = PTR_BITS'(i);
      end
   end

endmodule

// File: rtl/table_access_arbiter.sv
// Shares one synchronous-read lookup table among N_REQ requesters with
// round-robin grant and per-requester response registers.
// Optional grant/stall statistics when TABLE_ARB_STATS_EN is defined.
module table_access_arbiter
   import table_arb_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int ADDR_BITS  = 8,
   parameter int REAL_WIDTH = 18,
   parameter int SINT_BITS  = 8,
   parameter int UINT_BITS  = 8,
   parameter int TBL_LAT    = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*ADDR_BITS-1:0]  req_addr,
   output logic [N_REQ-1:0]            req_ready,
   output logic [N_REQ-1:0]            resp_valid,
   input  logic [N_REQ-1:0]            resp_ready,
   output logic [N_REQ*REAL_WIDTH-1:0] resp_real,
   output logic [N_REQ*SINT_BITS-1:0]  resp_sint,
   output logic [N_REQ*UINT_BITS-1:0]  resp_uint,
   output logic [ADDR_BITS-1:0]        tbl_addr,
   output logic                        tbl_rd,
   input  logic [REAL_WIDTH-1:0]       tbl_real,
   input  logic [SINT_BITS-1:0]        tbl_sint,
   input  logic [UINT_BITS-1:0]        tbl_uint
`ifdef TABLE_ARB_STATS_EN
   ,
   output logic [N_REQ*16-1:0]         stat_grants,
   output logic [15:0]                 stat_stall
`endif
);

   // Stage 0 lines up with tbl_rd; the last stage lines up with valid table data.
   localparam int PIPE_DEPTH = TBL_LAT + 1;

   logic [PTR_BITS-1:0]         ptr_q, ptr_d;
   tbl_pipe_t                   pipe_q [PIPE_DEPTH];
   tbl_pipe_t                   cap;
   logic                        tbl_rd_q;
   logic [ADDR_BITS-1:0]        tbl_addr_q;
   logic [N_REQ-1:0]            resp_valid_q;
   logic [N_REQ*REAL_WIDTH-1:0] resp_real_q;
   logic [N_REQ*SINT_BITS-1:0]  resp_sint_q;
   logic [N_REQ*UINT_BITS-1:0]  resp_uint_q;

   logic [N_REQ-1:0]            busy, eligible, grant;
   logic [PTR_BITS-1:0]         grant_idx;
   logic                        grant_any;

   assign cap = pipe_q[PIPE_DEPTH-1];

   always_comb begin
      busy = resp_valid_q & ~resp_ready;
      for (int s = 0; s < PIPE_DEPTH; s++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (pipe_q[s].vld && pipe_q[s].id == PTR_BITS'(i)) busy[i] = 1'b1;
         end
      end
      // Gating with rst_n keeps req_ready low while reset is asserted.
      eligible = req_valid & ~busy & {N_REQ{rst_n}};
   end

   table_arb_rr #(.N_REQ(N_REQ)) u_rr (
      .eligible_i  (eligible),
      .ptr_i       (ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx),
      .any_o       (grant_any)
   );

   always_comb begin
      ptr_d = ptr_q;
      if (grant_any) begin
         ptr_d = (grant_idx == PTR_BITS'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         tbl_rd_q   <= 1'b0;
         tbl_addr_q <= '0;
         for (int s = 0; s < PIPE_DEPTH; s++) pipe_q[s] <= '0;
      end else begin
         ptr_q    <= ptr_d;
         tbl_rd_q <= grant_any;
         if (grant_any) tbl_addr_q <= req_addr[int'(grant_idx)*ADDR_BITS +: ADDR_BITS];
         pipe_q[0] <= '{vld: grant_any, id: grant_idx};
         for (int s = 1; s < PIPE_DEPTH; s++) pipe_q[s] <= pipe_q[s-1];
      end
   end

   // A capture for i takes priority over a consume of i on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_q <= '0;
         resp_real_q  <= '0;
         resp_sint_q  <= '0;
         resp_uint_q  <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (cap.vld && cap.id == PTR_BITS'(i)) begin
               resp_valid_q[i]                          <= 1'b1;
               resp_real_q[i*REAL_WIDTH +: REAL_WIDTH]  <= tbl_real;
               resp_sint_q[i*SINT_BITS +: SINT_BITS]    <= tbl_sint;
               resp_uint_q[i*UINT_BITS +: UINT_BITS]    <= tbl_uint;
            end else if (resp_valid_q[i] && resp_ready[i]) begin
               resp_valid_q[i] <= 1'b0;
            end
         end
      end
   end

   assign req_ready  = grant;
   assign resp_valid = resp_valid_q;
   assign resp_real  = resp_real_q;
   assign resp_sint  = resp_sint_q;
   assign resp_uint  = resp_uint_q;
   assign tbl_addr   = tbl_addr_q;
   assign tbl_rd     = tbl_rd_q;

`ifdef TABLE_ARB_STATS_EN
   logic [N_REQ*16-1:0] stat_grants_q;
   logic [15:0]         stat_stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_grants_q <= '0;
         stat_stall_q  <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (grant[i] && stat_grants_q[i*16 +: 16] != 16'hFFFF) begin
               stat_grants_q[i*16 +: 16] <= stat_grants_q[i*16 +: 16] + 16'd1;
            end
         end
         if (|req_valid && !grant_any && stat_stall_q != 16'hFFFF) begin
            stat_stall_q <= stat_stall_q + 16'd1;
         end
      end
   end

   assign stat_grants = stat_grants_q;
   assign stat_stall  = stat_stall_q;
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_table_access_arbiter.sv
// Directed self-checking bench for table_access_arbiter (N_REQ=4, TBL_LAT=1)
// with a registered lookup-table model.
module tb_table_access_arbiter;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int RW = 18;
   localparam int SW = 8;
   localparam int UW = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    resp_valid;
   logic [N-1:0]    resp_ready;
   logic [N*RW-1:0] resp_real;
   logic [N*SW-1:0] resp_sint;
   logic [N*UW-1:0] resp_uint;
   logic [AW-1:0]   tbl_addr;
   logic            tbl_rd;
   logic [RW-1:0]   tbl_real = '0;
   logic [SW-1:0]   tbl_sint = '0;
   logic [UW-1:0]   tbl_uint = '0;
`ifdef TABLE_ARB_STATS_EN
   logic [N*16-1:0] stat_grants;
   logic [15:0]     stat_stall;
`endif

   int n_tot = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   table_access_arbiter #(
      .N_REQ(N), .ADDR_BITS(AW), .REAL_WIDTH(RW),
      .SINT_BITS(SW), .UINT_BITS(UW), .TBL_LAT(1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_real  (resp_real),
      .resp_sint  (resp_sint),
      .resp_uint  (resp_uint),
      .tbl_addr   (tbl_addr),
      .tbl_rd     (tbl_rd),
      .tbl_real   (tbl_real),
      .tbl_sint   (tbl_sint),
      .tbl_uint   (tbl_uint)
`ifdef TABLE_ARB_STATS_EN
      ,
      .stat_grants(stat_grants),
      .stat_stall (stat_stall)
`endif
   );

   // Table contents: real = 3*a+7, sint = ~a, uint = a ^ 8'h5A.
   function automatic logic [RW-1:0] f_real(input logic [AW-1:0] a);
      return RW'(a) * 18'd3 + 18'd7;
   endfunction
   function automatic logic [SW-1:0] f_sint(input logic [AW-1:0] a);
      return ~a;
   endfunction
   function automatic logic [UW-1:0] f_uint(input logic [AW-1:0] a);
      return a ^ 8'h5A;
   endfunction

   always @(posedge clk) begin
      if (tbl_rd) begin
         tbl_real <= f_real(tbl_addr);
         tbl_sint <= f_sint(tbl_addr);
         tbl_uint <= f_uint(tbl_addr);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step();
      rst_n      = 1'b0;
      req_valid  = '0;
      resp_ready = '0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0]    exp_r;
      logic [AW-1:0] a;
      int            g;
      logic [3:0]    bp_exp [10];
      bp_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h4, 4'h8, 4'h1, 4'h4, 4'h8};

      rst_n      = 1'b0;
      req_valid  = '0;
      req_addr   = '0;
      resp_ready = '0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_tbl_rd", 32'(tbl_rd), 32'h0);
      chk("rst_tbl_addr", 32'(tbl_addr), 32'h0);
      chk("rst_resp_real", 32'(resp_real[RW-1:0]), 32'h0);
      chk("rst_resp_sint", 32'(resp_sint), 32'h0);
      step();
      rst_n = 1'b1;

      // single request from requester 2, address 5
      req_valid          = 4'b0100;
      req_addr[2*AW +: AW] = 8'h05;
      @(negedge clk);
      chk("s1_ready", 32'(req_ready), 32'h4);
      step();
      req_valid = '0;
      @(negedge clk);
      chk("s1_tbl_rd", 32'(tbl_rd), 32'h1);
      chk("s1_tbl_addr", 32'(tbl_addr), 32'h05);
      chk("s1_rv_c1", 32'(resp_valid), 32'h0);
      step();
      @(negedge clk);
      chk("s1_rv_c2", 32'(resp_valid), 32'h0);
      chk("s1_tbl_rd_off", 32'(tbl_rd), 32'h0);
      step();
      @(negedge clk);
      chk("s1_rv_c3", 32'(resp_valid), 32'h4);
      chk("s1_real", 32'(resp_real[2*RW +: RW]), 32'h16);
      chk("s1_sint", 32'(resp_sint[2*SW +: SW]), 32'hFA);
      chk("s1_uint", 32'(resp_uint[2*UW +: UW]), 32'h5F);
      step();
      @(negedge clk);
      chk("s1_hold_rv", 32'(resp_valid), 32'h4);
      chk("s1_hold_uint", 32'(resp_uint[2*UW +: UW]), 32'h5F);
      step();
      resp_ready = 4'b0100;
      req_valid  = 4'b1001;
      @(negedge clk);
      chk("s1_ptr3_ready", 32'(req_ready), 32'h8);
      chk("s1_rv_before_consume", 32'(resp_valid), 32'h4);
      step();
      req_valid = '0;
      @(negedge clk);
      chk("s1_consumed", 32'(resp_valid), 32'h0);

      // all four requesting every cycle, no backpressure
      do_reset();
      resp_ready = 4'hF;
      for (int k = 0; k <= 10; k++) begin
         req_valid = (k < 8) ? 4'hF : 4'h0;
         for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = 8'(i*40 + k);
         @(negedge clk);
         exp_r = (k < 8) ? 4'(1 << (k % 4)) : 4'h0;
         chk($sformatf("s2_ready_%0d", k), 32'(req_ready), 32'(exp_r));
         if (k >= 3) begin
            g = (k - 3) % 4;
            a = 8'(g*40 + k - 3);
            chk($sformatf("s2_rv_%0d", k), 32'(resp_valid), 32'(1 << g));
            chk($sformatf("s2_sint_%0d", k), 32'(resp_sint[g*SW +: SW]), 32'(f_sint(a)));
            chk($sformatf("s2_real_%0d", k), 32'(resp_real[g*RW +: RW]), 32'(f_real(a)));
         end else begin
            chk($sformatf("s2_rv_%0d", k), 32'(resp_valid), 32'h0);
         end
         step();
      end

      // requester 1 withholds resp_ready
      do_reset();
      resp_ready = 4'b1101;
      for (int k = 0; k < 10; k++) begin
         req_valid = 4'hF;
         for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = 8'(i*40 + k);
         @(negedge clk);
         chk($sformatf("s3_ready_%0d", k), 32'(req_ready), 32'(bp_exp[k]));
         if (k >= 4) chk($sformatf("s3_rv1_%0d", k), 32'(resp_valid[1]), 32'h1);
         if (k == 9) chk("s3_uint1_held", 32'(resp_uint[1*UW +: UW]), 32'h73);
         step();
      end
      req_valid  = 4'b0010;
      resp_ready = 4'hF;
      @(negedge clk);
      chk("s3_regrant1", 32'(req_ready), 32'h2);
      step();
      req_valid = '0;
      step();
      step();
      step();

      // requester 0 back-to-back: consume and new grant in the same cycle
      do_reset();
      resp_ready = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         req_valid          = 4'b0001;
         req_addr[0 +: AW]  = 8'h10 + 8'(k);
         @(negedge clk);
         chk($sformatf("s4_ready_%0d", k), 32'(req_ready), (k % 3 == 0) ? 32'h1 : 32'h0);
         if (k >= 1) chk($sformatf("s4_rv_%0d", k), 32'(resp_valid), (k == 3 || k == 6) ? 32'h1 : 32'h0);
         if (k == 3) chk("s4_sint_a", 32'(resp_sint[0 +: SW]), 32'hEF);
         if (k == 6) chk("s4_sint_b", 32'(resp_sint[0 +: SW]), 32'hEC);
         step();
      end
      req_valid = '0;

      // reset one cycle after accept
      do_reset();
      req_valid            = 4'b0100;
      req_addr[2*AW +: AW] = 8'h33;
      @(negedge clk);
      chk("s5_ready", 32'(req_ready), 32'h4);
      step();
      rst_n     = 1'b0;
      req_valid = 4'hF;
      @(negedge clk);
      chk("s5_rst_tbl_rd", 32'(tbl_rd), 32'h0);
      chk("s5_rst_tbl_addr", 32'(tbl_addr), 32'h0);
      chk("s5_rst_ready", 32'(req_ready), 32'h0);
      chk("s5_rst_rv", 32'(resp_valid), 32'h0);
      step();
      req_valid = '0;
      rst_n     = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("s5_no_stray_%0d", k), 32'(resp_valid), 32'h0);
         step();
      end
      req_valid = 4'hF;
      @(negedge clk);
      chk("s5_ptr0", 32'(req_ready), 32'h1);
      step();
      req_valid = '0;

`ifdef TABLE_ARB_STATS_EN
      do_reset();
      resp_ready = 4'hF;
      for (int n = 0; n < 10; n++) begin
         req_valid = 4'b1000;
         step();
         req_valid = (n == 9) ? 4'b1000 : 4'b0000;
         step();
         step();
      end
      req_valid = '0;
      step();
      @(negedge clk);
      chk("st_grants3", 32'(stat_grants[3*16 +: 16]), 32'd10);
      chk("st_grants0", 32'(stat_grants[0 +: 16]), 32'd0);
      chk("st_stall", 32'(stat_stall), 32'd2);
`endif

      step();
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
